// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand/result handshake bundle between execute-stage muxes, alu_pipe and EX/MEM.
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ealuc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             illegal;

  modport master (
    output in_valid, a, b, ealuc, out_ready,
    input  in_ready, out_valid, result, zero, ovf, illegal
  );

  modport slave (
    input  in_valid, a, b, ealuc, out_ready,
    output in_ready, out_valid, result, zero, ovf, illegal
  );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU, 1-cycle ops plus optional iterative shift-add MUL.
// Define ALU_MUL_EN to build the MUL state and multiplier; otherwise ealuc=10 is illegal.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic     clk,
  input  logic     clrn,
  alu_pipe_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, MUL = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
`endif

  state_t           state;
  state_t           state_nx;
  state_t           start_st;
  logic             accept;
  logic             is_mul;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [CW-1:0]    cnt;

  assign is_mul   = (bus.ealuc == 4'd10);
  assign start_st = is_mul ? MUL : HOLD;
  assign acc_nx   = acc + (mplier[0] ? mcand : '0);
`else
  assign is_mul   = 1'b0;
  assign start_st = HOLD;
`endif

  assign shamt  = bus.b[SHW-1:0];
  assign sum    = bus.a + bus.b;
  assign diff   = bus.a - bus.b;
  assign accept = bus.in_valid & bus.in_ready;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (bus.ealuc)
      4'd0:  alu_res = bus.a & bus.b;
      4'd1:  alu_res = bus.a | bus.b;
      4'd2: begin
        alu_res = sum;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'd3:  alu_res = bus.a ^ bus.b;
      4'd4:  alu_res = bus.a << shamt;
      4'd5:  alu_res = bus.a >> shamt;
      4'd6: begin
        alu_res = diff;
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'd7:  alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      4'd8:  alu_res = $unsigned($signed(bus.a) >>> shamt);
      4'd9:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
`ifdef ALU_MUL_EN
      4'd10: alu_res = '0;
`endif
      4'd12: alu_res = ~(bus.a | bus.b);
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // HOLD passes out_ready straight to in_ready so a drained result can be refilled on the same edge.
  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_nx = start_st;
        end
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
        if (bus.out_ready && bus.in_valid) begin
          state_nx = start_st;
        end else if (bus.out_ready) begin
          state_nx = IDLE;
        end
      end
`ifdef ALU_MUL_EN
      MUL: begin
        if (cnt == '0) begin
          state_nx = HOLD;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bus.result  <= '0;
      bus.zero    <= 1'b0;
      bus.ovf     <= 1'b0;
      bus.illegal <= 1'b0;
`ifdef ALU_MUL_EN
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
`endif
    end else begin
      if (accept && !is_mul) begin
        bus.result  <= alu_res;
        bus.zero    <= (alu_res == '0);
        bus.ovf     <= alu_ovf;
        bus.illegal <= alu_ill;
      end
`ifdef ALU_MUL_EN
      if (accept && is_mul) begin
        mcand  <= bus.a;
        mplier <= bus.b;
        acc    <= '0;
        cnt    <= CW'(WIDTH - 1);
      end else if (state == MUL) begin
        acc    <= acc_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        // Last step publishes the low WIDTH bits of the product directly.
        if (cnt == '0) begin
          bus.result  <= acc_nx;
          bus.zero    <= (acc_nx == '0);
          bus.ovf     <= 1'b0;
          bus.illegal <= 1'b0;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe with directed vectors.
module tb_alu_pipe;
  localparam int W = 32;

  typedef struct packed {
    logic         ill;
    logic         ovf;
    logic         zero;
    logic [W-1:0] res;
  } exp_t;

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus ();
  alu_pipe #(.WIDTH(W), .SHW(5)) dut (.clk(clk), .clrn(clrn), .bus(bus));

  exp_t  expq[$];
  string namq[$];
  int    pop_cyc[$];
  int    pass_cnt = 0;
  int    chk_cnt  = 0;
  int    cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t  got;
    exp_t  e;
    string nm;
    if (clrn && bus.out_valid && bus.out_ready) begin
      got = {bus.illegal, bus.ovf, bus.zero, bus.result};
      if (expq.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_output: got 0x%0h required no output", got);
      end else begin
        e  = expq.pop_front();
        nm = namq.pop_front();
        check(nm, 64'(got), 64'(e));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic [W-1:0] r, input logic z, input logic o, input logic i,
                      input bit push, input string nm);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.ealuc    = op;
    bus.a        = aa;
    bus.b        = bb;
    if (push) begin
      expq.push_back({i, o, z, r});
      namq.push_back(nm);
    end
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 200);
    if (!bus.in_ready) begin
      chk_cnt++;
      $display("FAIL accept_timeout %s: in_ready got 0 required 1", nm);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    int n;
    int stall;
    int ov;
    int exp_stall;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.ealuc     = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result",    64'(bus.result),    64'd0);
    check("rst_flags",     64'({bus.zero, bus.ovf, bus.illegal}), 64'd0);
    clrn = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    send(4'd2,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0, 1, 0, 1, "add_ovf");
    send(4'd6,  32'd5,         32'd5,         32'h0,         1, 0, 0, 1, "sub_zero");
    send(4'd9,  32'hFFFF_FFFF, 32'h1,         32'h1,         0, 0, 0, 1, "slt");
    send(4'd7,  32'hFFFF_FFFF, 32'h1,         32'h0,         1, 0, 0, 1, "sltu");
    send(4'd8,  32'h8000_0000, 32'd4,         32'hF800_0000, 0, 0, 0, 1, "sra");
    send(4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0, 1, "and");
    send(4'd1,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, 0, 0, 1, "or");
    send(4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0, 0, 1, "xor");
    send(4'd12, 32'h0,         32'h0,         32'hFFFF_FFFF, 0, 0, 0, 1, "nor");
    send(4'd4,  32'h1,         32'd31,        32'h8000_0000, 0, 0, 0, 1, "sll31");
    send(4'd4,  32'h1,         32'h21,        32'h2,         0, 0, 0, 1, "sll_mask");
    send(4'd5,  32'h8000_0000, 32'h24,        32'h0800_0000, 0, 0, 0, 1, "srl_mask");
    send(4'd6,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 0, 1, 0, 1, "sub_ovf");
    send(4'd2,  32'hFFFF_FFFF, 32'h1,         32'h0,         1, 0, 0, 1, "add_wrap");
    send(4'd11, 32'h1234,      32'h5678,      32'h0,         1, 0, 1, 1, "illegal11");
    repeat (2) @(posedge clk);
    #1;

    idx = pop_cyc.size();
    send(4'd2, 32'd1,      32'd2,   32'd3,      0, 0, 0, 1, "b2b_0");
    send(4'd2, 32'd10,     32'd20,  32'd30,     0, 0, 0, 1, "b2b_1");
    send(4'd2, 32'd100,    32'd200, 32'd300,    0, 0, 0, 1, "b2b_2");
    send(4'd2, 32'h1000,   32'h1,   32'h1001,   0, 0, 0, 1, "b2b_3");
    repeat (2) @(posedge clk);
    #1;
    if (pop_cyc.size() < idx + 4) begin
      chk_cnt++;
      $display("FAIL b2b_count: got %0d results required 4", pop_cyc.size() - idx);
    end else begin
      for (int k = 1; k < 4; k++)
        check("b2b_spacing", 64'(pop_cyc[idx+k] - pop_cyc[idx+k-1]), 64'd1);
    end

    bus.out_ready = 1'b0;
    send(4'd2, 32'h11, 32'h22, 32'h33, 0, 0, 0, 1, "stall_p");
    fork
      send(4'd2, 32'd7, 32'd8, 32'd15, 0, 0, 0, 1, "stall_q");
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready",  64'(bus.in_ready),  64'd0);
          check("stall_out_valid", 64'(bus.out_valid), 64'd1);
          check("stall_result",    64'(bus.result),    64'h33);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;

`ifdef ALU_MUL_EN
    send(4'd10, 32'd1234, 32'd5678, 32'd7006652, 0, 0, 0, 1, "mul");
    exp_stall = 32;
`else
    send(4'd10, 32'd1234, 32'd5678, 32'd0, 1, 0, 1, 1, "mul_illegal");
    exp_stall = 0;
`endif
    stall = 0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (bus.out_valid) break;
      if (!bus.in_ready) stall++;
    end
    check("mul_stall_cycles", 64'(stall), 64'(exp_stall));
    repeat (2) @(posedge clk);
    #1;

`ifdef ALU_MUL_EN
    send(4'd10, 32'd3, 32'd3, 32'd0, 0, 0, 0, 0, "mul_abort");
`else
    send(4'd10, 32'd3, 32'd3, 32'd0, 1, 0, 1, 1, "mul_abort_illegal");
`endif
    repeat (9) @(negedge clk);
    #2;
    clrn = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_rst_result",    64'(bus.result),    64'd0);
    check("async_rst_flags",     64'({bus.zero, bus.ovf, bus.illegal}), 64'd0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    ov = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) ov++;
    end
    check("abort_no_output", 64'(ov), 64'd0);
    @(posedge clk);
    #1;
    send(4'd2, 32'd1, 32'd1, 32'd2, 0, 0, 0, 1, "add_after_abort");
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(expq.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
